fb_writer: RTL

Framebuffer write-side engine: accepts a stream of 4-bit pixels with a start-of-frame marker and writes them into the pixel memory at the linear addresses that the VGA scan path later reads (address = BASE_ADDR + y·H_RES + x). The block sits between the image-processing datapath and the framebuffer memory write port, opposite the VGA read path. It stalls cleanly on memory back-pressure and pulses a flag at each completed frame.

---
 rtl/fb_pkg.sv | 23 ++
 rtl/fb_xy_counter.sv | 54 +++++
 rtl/fb_writer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// fb_pkg: shared types and defaults for the framebuffer write engine.
// Holds the FSM state encoding, default geometry/width constants and the
// frame-size helper used for elaboration-time range checking.
package fb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam int DEF_H_RES  = 640;
    localparam int DEF_V_RES  = 480;
    localparam int DEF_DATA_W = 4;
    localparam int DEF_ADDR_W = 24;

    // Number of pixels in one frame, widened so large geometries cannot overflow.
    function automatic longint unsigned frame_size(input int h, input int v);
        return longint'(h) * longint'(v);
    endfunction

endpackage

// File: rtl/fb_xy_counter.sv
// fb_xy_counter: raster position tracker for the framebuffer writer.
// Tracks the (x, y) position of the next incoming pixel, keeps the matching
// linear address as a running counter (no multiplier), and flags when the
// next pixel is the last one of the frame.
//   restart : next pixel becomes (1, 0) - the SOF pixel itself went to BASE_ADDR
//   advance : step one pixel in raster order
module fb_xy_counter
    import fb_pkg::*;
#(
    parameter int H_RES     = DEF_H_RES,
    parameter int V_RES     = DEF_V_RES,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              restart,
    input  logic              advance,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    localparam int XW = $clog2(H_RES + 1);
    localparam int YW = $clog2(V_RES + 1);

    logic [XW-1:0] x;
    logic [YW-1:0] y;

    assign last = (x == XW'(H_RES - 1)) && (y == YW'(V_RES - 1));

    // Position and linear address of the pixel expected next.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x    <= '0;
            y    <= '0;
            addr <= ADDR_W'(BASE_ADDR);
        end else if (restart) begin
            x    <= XW'(1);
            y    <= '0;
            addr <= ADDR_W'(BASE_ADDR) + ADDR_W'(1);
        end else if (advance) begin
            if (x == XW'(H_RES - 1)) begin
                x <= '0;
                y <= y + YW'(1);
            end else begin
                x <= x + XW'(1);
            end
            addr <= addr + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/fb_writer.sv
// fb_writer: framebuffer write-side engine.
// Accepts a valid/ready pixel stream with a start-of-frame marker and writes
// each pixel to BASE_ADDR + y*H_RES + x through a single output register
// slot that holds address/data stable under memory back-pressure. Pulses
// frame_done once the last pixel of a frame has been accepted by memory.
// Build option FB_WRITER_ERRCNT_EN: when defined, an s_sof seen mid-frame
// restarts the frame and bumps a saturating err_count; when undefined the
// marker is ignored mid-frame and err_count is tied to zero.
module fb_writer
    import fb_pkg::*;
#(
    parameter int H_RES     = DEF_H_RES,
    parameter int V_RES     = DEF_V_RES,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_sof,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              frame_done,
    output logic              busy,
    output logic [7:0]        err_count
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    // The whole frame must be addressable above BASE_ADDR.
    if (longint'(BASE_ADDR) + longint'(frame_size(H_RES, V_RES)) > longint'(64'd1 << ADDR_W)) begin : g_size_chk
        $error("fb_writer: BASE_ADDR + H_RES*V_RES exceeds the ADDR_W address space");
    end

    state_t            state, state_nxt;
    logic              slot_free;
    logic              take;
    logic              sof_err;
    logic              load;
    logic              load_base;
    logic              ctr_restart;
    logic              ctr_advance;
    logic [ADDR_W-1:0] ctr_addr;
    logic              ctr_last;

    // The slot can take a pixel when empty or when its write retires this cycle.
    assign slot_free = !mem_we || mem_ready;
    // A beat would happen here if the current state offers ready.
    assign take      = s_valid && slot_free && !rst;

`ifdef FB_WRITER_ERRCNT_EN
    assign sof_err = s_sof;
`else
    assign sof_err = 1'b0;
`endif

    fb_xy_counter #(
        .H_RES    (H_RES),
        .V_RES    (V_RES),
        .ADDR_W   (ADDR_W),
        .BASE_ADDR(BASE_ADDR)
    ) u_xy (
        .clk    (clk),
        .rst    (rst),
        .restart(ctr_restart),
        .advance(ctr_advance),
        .addr   (ctr_addr),
        .last   (ctr_last)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic, handshake outputs and slot/counter control.
    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt   = state;
        s_ready     = 1'b0;
        busy        = 1'b0;
        frame_done  = 1'b0;
        load        = 1'b0;
        load_base   = 1'b0;
        ctr_restart = 1'b0;
        ctr_advance = 1'b0;
        case (state)
            ST_IDLE: begin
                s_ready = slot_free && !rst;
                if (take && s_sof) begin
                    load        = 1'b1;
                    load_base   = 1'b1;
                    ctr_restart = 1'b1;
                    state_nxt   = ST_WRITE;
                end
            end
            ST_WRITE: begin
                busy    = 1'b1;
                s_ready = slot_free && !rst;
                if (take) begin
                    load = 1'b1;
                    if (sof_err) begin
                        load_base   = 1'b1;
                        ctr_restart = 1'b1;
                    end else begin
                        ctr_advance = 1'b1;
                        if (ctr_last) state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (mem_we && mem_ready) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                frame_done = 1'b1;
                state_nxt  = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output slot: loads on a beat, holds while the memory stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (slot_free) begin
            mem_we <= load;
            if (load) begin
                mem_addr  <= load_base ? BASE : ctr_addr;
                mem_wdata <= s_data;
            end
        end
    end

`ifdef FB_WRITER_ERRCNT_EN
    logic err_inc;
    assign err_inc = (state == ST_WRITE) && take && s_sof;

    // Saturating count of start-of-frame markers seen mid-frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                             err_count <= '0;
        else if (err_inc && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
`else
    assign err_count = '0;
`endif

endmodule
